// File: rtl/gray_counter_seq.sv
// Registered binary/Gray up-down counter with load, wrap/saturate and terminal-count pulse.
// Optional Gray-step monitor for err_o is built only when GRAY_COUNTER_CHECK_EN is defined.
module gray_counter_seq #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             tc_o,
    output logic             err_o
);

    localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] MAX_BIN = '1;

    logic [WIDTH-1:0] bin_next;
    logic             tc_next;

    always_comb begin
        bin_next = bin_o;
        tc_next  = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            if (up) begin
                if (bin_o == MAX_BIN) begin
                    tc_next  = 1'b1;
                    bin_next = SATURATE ? MAX_BIN : '0;
                end else begin
                    bin_next = bin_o + 1'b1;
                end
            end else begin
                if (bin_o == '0) begin
                    tc_next  = 1'b1;
                    bin_next = SATURATE ? '0 : MAX_BIN;
                end else begin
                    bin_next = bin_o - 1'b1;
                end
            end
        end
    end

    // Gray is derived from the next binary value so both registers update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_o  <= RST_BIN;
            gray_o <= RST_BIN ^ (RST_BIN >> 1);
            tc_o   <= 1'b0;
        end else begin
            bin_o  <= bin_next;
            gray_o <= bin_next ^ (bin_next >> 1);
            tc_o   <= tc_next;
        end
    end

`ifdef GRAY_COUNTER_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             chk_valid;
    logic [WIDTH-1:0] gray_diff;

    assign gray_diff = gray_o ^ prev_gray;

    // chk_valid drops for the cycle after a load or reset, whose step is legitimately arbitrary.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            chk_valid <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            prev_gray <= gray_o;
            chk_valid <= !load;
            if (chk_valid && ((gray_diff & (gray_diff - 1'b1)) != '0)) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_seq.sv
// Directed bench: dut0 wraps (RESET_VAL=5), dut1 saturates (RESET_VAL=0); both share the inputs.
module tb_gray_counter_seq;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin0, gray0, bin1, gray1;
    logic         tc0, err0, tc1, err1;

    int tests = 0;
    int fails = 0;

    gray_counter_seq #(.WIDTH(W), .SATURATE(1'b0), .RESET_VAL(5)) dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .bin_o(bin0), .gray_o(gray0), .tc_o(tc0), .err_o(err0)
    );

    gray_counter_seq #(.WIDTH(W), .SATURATE(1'b1), .RESET_VAL(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .bin_o(bin1), .gray_o(gray1), .tc_o(tc1), .err_o(err1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst, load, en, up;
        logic [W-1:0] load_bin;
        logic [W-1:0] exp_bin, exp_gray;
        logic         exp_tc;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input logic [W-1:0] lb);
        rst = r; load = l; en = e; up = u; load_bin = lb;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_b, exp_g, prev_g, d;

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_bin = '0;

        //            rst   load  en    up    load_bin  bin      gray     tc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h005, 10'h007, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h006, 10'h005, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h005, 10'h007, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 10'h005, 10'h007, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h200, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3FF, 10'h200, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h000, 10'h000, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3FF, 10'h200, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h3FF, 10'h200, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 10'h1FF, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'h000, 10'h156, 10'h1FD, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h005, 10'h007, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h004, 10'h006, 1'b0};

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_bin);
            chk($sformatf("vec%0d_bin", i),  32'(bin0),  32'(vecs[i].exp_bin));
            chk($sformatf("vec%0d_gray", i), 32'(gray0), 32'(vecs[i].exp_gray));
            chk($sformatf("vec%0d_tc", i),   32'(tc0),   32'(vecs[i].exp_tc));
        end

        // Exhaustive up-count on dut0 from 0 through the wrap and one cycle beyond.
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        prev_g = gray0;
        exp_b  = '0;
        for (int i = 1; i <= 1025; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
            exp_b = exp_b + 1'b1;
            exp_g = exp_b ^ (exp_b >> 1);
            d     = gray0 ^ prev_g;
            chk("sweep_bin",  32'(bin0),  32'(exp_b));
            chk("sweep_gray", 32'(gray0), 32'(exp_g));
            chk("sweep_onebit", 32'($countones(d)), 32'd1);
            chk("sweep_tc", 32'(tc0), (i == 1024) ? 32'd1 : 32'd0);
            prev_g = gray0;
        end
        chk("sweep_end_bin", 32'(bin0), 32'd1);

        // Saturating down-count against 0 on dut1: tc every cycle, count held.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("sat_rst_bin", 32'(bin1), 32'd0);
        chk("sat_rst_tc",  32'(tc1),  32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
            chk("sat_dn_bin",  32'(bin1),  32'd0);
            chk("sat_dn_gray", 32'(gray1), 32'd0);
            chk("sat_dn_tc",   32'(tc1),   32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("sat_idle_tc", 32'(tc1), 32'd0);

        // Saturating at the top, then direction reversal with no bubble.
        step(1'b0, 1'b1, 1'b1, 1'b1, 10'h3FF);
        chk("sat_ld_tc", 32'(tc1), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
        chk("sat_up_bin",  32'(bin1),  32'h3FF);
        chk("sat_up_gray", 32'(gray1), 32'h200);
        chk("sat_up_tc",   32'(tc1),   32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
        chk("sat_rev_bin",  32'(bin1),  32'h3FE);
        chk("sat_rev_gray", 32'(gray1), 32'h201);
        chk("sat_rev_tc",   32'(tc1),   32'd0);

`ifdef GRAY_COUNTER_CHECK_EN
        chk("mon_clean", 32'(err0), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        force dut0.gray_o = gray0 ^ 10'h003;
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        release dut0.gray_o;
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("mon_err_set", 32'(err0), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
        chk("mon_err_sticky", 32'(err0), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("mon_err_clear", 32'(err0), 32'd0);
`else
        chk("err_tied0", 32'(err0), 32'd0);
        chk("err_tied1", 32'(err1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gray_counter_seq.md
Name: gray_counter_seq

Overview:
- Parametrised, registered binary/Gray up-down counter.
- Successor to the combinational bin-to-Gray encoder: it holds the count in a register and presents both binary and Gray outputs, glitch-free and cycle-aligned.
- Adds load, direction, wrap/saturate mode and terminal-count signalling.
- Used as a pointer or sequence generator feeding clock-domain-crossing logic, which samples gray_o.

Parameters:
- WIDTH, 10: counter and output width in bits (>= 2).
- SATURATE, 0: boundary mode. 0 = wrap around; 1 = hold at the boundary value.
- RESET_VAL, 0: binary value loaded on reset. Must be < 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  synchronous load of load_bin.
- load_bin  input  WIDTH  binary value to load.
- bin_o  output  WIDTH  registered binary count.
- gray_o  output  WIDTH  registered Gray code of bin_o.
- tc_o  output  1  one-cycle terminal-count pulse.
- err_o  output  1  sticky Gray-step error flag (see Optional Feature).

Behaviour:
- Reset, at a clk edge with rst=1:
  - bin_o = RESET_VAL
  - gray_o = RESET_VAL ^ (RESET_VAL >> 1)
  - tc_o = 0, err_o = 0
- Priority per edge: rst > load > en. When load=1, en and up are ignored.
- Load: bin_o = load_bin and gray_o = load_bin ^ (load_bin >> 1) on the next edge; tc_o = 0.
- Count, with en=1 and load=0:
  - next = bin_o + 1 if up=1, else bin_o - 1.
  - Arithmetic is unsigned, modulo 2^WIDTH.
- Gray generation:
  - gray_o is computed from the next binary value and registered in the same edge as bin_o.
  - Both outputs therefore change on the same edge, with zero relative latency.
  - The shift is logical; the MSB of gray_o equals the MSB of bin_o.
- No-op: en=0 and load=0 hold all outputs; tc_o = 0.
- Boundary, up at 2^WIDTH-1:
  - SATURATE=0: wrap to 0.
  - SATURATE=1: hold at 2^WIDTH-1.
  - In both modes tc_o = 1 for exactly the following cycle.
- Boundary, down at 0:
  - SATURATE=0: wrap to 2^WIDTH-1.
  - SATURATE=1: hold at 0.
  - In both modes tc_o = 1 for exactly the following cycle.
- Saturated hold: while en stays high against the limit, tc_o pulses every cycle.
- Direction change mid-run takes effect on the same edge; no bubble.
- Load of any value, including boundary values, never asserts tc_o.
- Reset mid-count wins unconditionally; the next count starts from RESET_VAL.
- In normal counting (no load or reset), consecutive gray_o values differ in exactly one bit, including across wrap. Saturated holds differ in zero bits.

Optional Feature:
- Macro: GRAY_COUNTER_CHECK_EN.
- Defined: an internal monitor compares gray_o with its previous-cycle value.
  - If they differ in more than one bit, err_o is set and stays high until rst.
  - Cycles following a load or reset are excluded from the check.
- Not defined: err_o is tied to 0 and no monitor logic is built.

Test Plan:
- Reset with RESET_VAL=5, WIDTH=10 -> bin_o=5, gray_o=10'b0000000111, tc_o=0.
- Exhaustive up count, 1024 en cycles from 0, SATURATE=0, then one more cycle:
  - Every cycle: gray_o = bin_o ^ (bin_o >> 1) and a single-bit change.
  - After 1024 cycles: 1023 -> 0 wrap (gray_o 10'b1000000000 -> 0), with tc_o high for one cycle.
  - The extra cycle after the wrap -> bin_o = 1 and tc_o = 0.
- Down count from 0, SATURATE=1, en held 3 cycles -> bin_o stays 0; tc_o high on all 3 following cycles.
- load=1, en=1, up=1, load_bin=10'h3FF -> bin_o=1023, gray_o=10'h200, tc_o=0. Next en cycle wraps to 0 with tc_o=1.
- rst asserted concurrently with load=1 and en=1 mid-count -> RESET_VAL state; load ignored.
- With GRAY_COUNTER_CHECK_EN:
  - Full up/down sweep with loads -> err_o stays 0.
  - Force a 2-bit gray_o jump (bind/force) -> err_o=1 next cycle, sticky until rst.
